// File: rtl/parking_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : parking_display_mux
// Brief    : Sequential binary-to-BCD conversion feeding a 4-digit multiplexed
//            seven-segment driver with leading-zero blanking and blinking.
// Revision : 1.0 - initial release
// ============================================================================
module parking_display_mux #(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_500Hz,
    input  logic              clk_2Hz,
    input  logic [VAL_W-1:0]  value,
    input  logic              value_load,
    input  logic              blink_en,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              busy,
    output logic              ovf
);

    localparam int c_BCD_W   = 4 * DIGITS;
    localparam int c_IDX_W   = $clog2(DIGITS);
    localparam int c_CNT_W   = $clog2(VAL_W);
    localparam int c_MAX_VAL = 9999;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(VAL_W - 1);
    localparam logic [VAL_W-1:0]   c_MAX_BIN  = VAL_W'(c_MAX_VAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Converter: BCD work nibbles sit above the binary operand in one shifter
    logic [c_BCD_W+VAL_W-1:0] r_shreg;
    logic [c_BCD_W-1:0]       w_adj;
    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_req;
    logic [VAL_W-1:0]         r_req_val;
    logic                     r_pending;
    logic                     r_busy;
    logic                     r_ovf;
    logic [c_BCD_W-1:0]       r_bcd;
    logic                     w_over;
    logic [VAL_W-1:0]         w_clamped;
    logic                     w_restart;
    logic                     w_load;

    // Scan and blink
    logic                     r_prev_500;
    logic                     r_prev_2;
    logic                     w_tick_500;
    logic                     w_tick_2;
    logic [c_IDX_W-1:0]       r_idx;
    logic [c_BCD_W-1:0]       r_view;
    logic                     r_scan_on;
    logic                     r_phase;
    logic [DIGITS-1:0]        r_an;
    logic [6:0]               r_seg;
    logic [c_IDX_W+1:0]       w_nib_sh;
    logic [3:0]               w_nib;
    logic                     w_blank;
    logic                     w_dark;
    logic [6:0]               w_seg_dec;

    assign w_tick_500 = clk_500Hz & ~r_prev_500;
    assign w_tick_2   = clk_2Hz & ~r_prev_2;

    assign w_over    = (r_req_val > c_MAX_BIN);
    assign w_clamped = w_over ? c_MAX_BIN : r_req_val;
    assign w_restart = r_pending | r_req;
    assign w_load    = ((r_state == S_IDLE) && r_req) ||
                       ((r_state == S_DONE) && w_restart);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [3:0] w_n;
            assign w_n = r_shreg[VAL_W + 4*gi +: 4];
            assign w_adj[4*gi +: 4] = (w_n >= 4'd5) ? (w_n + 4'd3) : w_n;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_req) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == c_LAST_CNT) w_next = S_DONE;
            S_DONE:  w_next = w_restart ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // value_load is registered first; that cycle is the capture step of the latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_req     <= 1'b0;
            r_req_val <= '0;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_req <= value_load;
            if (value_load) begin
                r_req_val <= value;
            end
            if (w_load) begin
                r_shreg   <= {{c_BCD_W{1'b0}}, w_clamped};
                r_cnt     <= '0;
                r_pending <= 1'b0;
                r_busy    <= 1'b1;
                r_ovf     <= w_over;
            end else if (r_state == S_SHIFT) begin
                r_shreg <= {w_adj, r_shreg[VAL_W-1:0]} << 1;
                r_cnt   <= r_cnt + c_CNT_W'(1);
                if (r_req) begin
                    r_pending <= 1'b1;
                end
            end else if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end
            if (r_state == S_DONE) begin
                r_bcd <= r_shreg[c_BCD_W+VAL_W-1 -: c_BCD_W];
            end
        end
    end

    assign w_nib_sh = {r_idx, 2'b00};
    assign w_nib    = r_view[w_nib_sh +: 4];
    assign w_blank  = (r_idx != '0) && ((r_view >> w_nib_sh) == '0);
    assign w_dark   = !r_scan_on || r_phase || w_blank;

    always_comb begin
        w_seg_dec = 7'b1111111;
        case (w_nib)
            4'd0: w_seg_dec = 7'b1000000;
            4'd1: w_seg_dec = 7'b1111001;
            4'd2: w_seg_dec = 7'b0100100;
            4'd3: w_seg_dec = 7'b0110000;
            4'd4: w_seg_dec = 7'b0011001;
            4'd5: w_seg_dec = 7'b0010010;
            4'd6: w_seg_dec = 7'b0000010;
            4'd7: w_seg_dec = 7'b1111000;
            4'd8: w_seg_dec = 7'b0000000;
            4'd9: w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b1111111;
        endcase
    end

    // The BCD snapshot is taken only on scan steps so a new result never forces a rescan
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_500 <= 1'b0;
            r_prev_2   <= 1'b0;
            r_idx      <= '0;
            r_view     <= '0;
            r_scan_on  <= 1'b0;
            r_phase    <= 1'b0;
            r_an       <= '1;
            r_seg      <= 7'b1111111;
        end else begin
            r_prev_500 <= clk_500Hz;
            r_prev_2   <= clk_2Hz;
            if (w_tick_500) begin
                r_idx     <= r_idx + c_IDX_W'(1);
                r_view    <= r_bcd;
                r_scan_on <= 1'b1;
            end
            if (!blink_en) begin
                r_phase <= 1'b0;
            end else if (w_tick_2) begin
                r_phase <= ~r_phase;
            end
            r_an  <= w_dark ? '1 : ~(DIGITS'(1) << r_idx);
            r_seg <= w_dark ? 7'b1111111 : w_seg_dec;
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign busy = r_busy;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: doc/parking_display_mux.md
# parking_display_mux

Four-digit seven-segment display driver for the parking system, sitting directly downstream of the frequency divider and consuming its `clk_500Hz` and `clk_2Hz` outputs. It converts a binary free-space count to BCD with a sequential shift-add-3 engine and multiplexes the four digits at the 500 Hz scan rate. It also blanks leading zeros and blinks the whole display at the 2 Hz rate when the lot is full. Divider outputs are treated as level signals sampled in the `clk` domain; they are never used as clocks.

## Interface
- `DIGITS`, 4: number of multiplexed digits; fixed at 4, other values are unsupported.
- `VAL_W`, 14: width of the binary input value.
- `clk` input 1: system clock, 40 MHz.
- `reset` input 1: synchronous, active-low reset.
- `clk_500Hz` input 1: scan-rate square wave from the divider.
- `clk_2Hz` input 1: blink-rate square wave from the divider.
- `value` input VAL_W: binary count to display, sampled at conversion start.
- `value_load` input 1: single-cycle request to convert `value`.
- `blink_en` input 1: level; when 1, the display blinks.
- `an` output 4: digit enables, active-low; at most one bit is low.
- `seg` output 7: segments, active-low, bit order {g,f,e,d,c,b,a}.
- `busy` output 1: high while a conversion is in progress.
- `ovf` output 1: high when the last converted value exceeded 9999.

## Operation
- **Edge detect:** each tick input has a previous-value register. `tick = in & ~prev`, evaluated every `clk` cycle.
- **Converter FSM** (IDLE → SHIFT → DONE → IDLE):
  - IDLE: on `value_load=1`, capture `value` clamped to 9999, set `ovf = (value > 9999)`, clear the 16-bit BCD work register, set `busy=1`, and go to SHIFT.
  - SHIFT: exactly 14 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left one bit, taking in the binary MSB.
  - DONE: copy the work register to the display register `bcd[15:0]`, drop `busy`, and return to IDLE.
  - `value_load` during SHIFT or DONE sets a `pending` flag. On leaving DONE with `pending=1`, the FSM clears `pending`, captures the current `value` and re-enters SHIFT; `busy` stays high.
- **Scan:** a 2-bit digit index increments on every 500 Hz tick and wraps 3 → 0. Digit 0 is the least significant.
- **Leading-zero blanking:** a digit is blanked (`an` bit high) when it and every more-significant digit are 0. Digit 0 is never blanked, so a value of 0 shows "0".
- **Blink:** a phase bit toggles on every 2 Hz tick while `blink_en=1`, and is forced to 0 when `blink_en=0`. When phase is 1, `an = 4'b1111`.
- **Decode:** BCD 0–9 maps to standard active-low segment patterns; for example 0 → 7'b1000000 and 8 → 7'b0000000.

## Timing
- **Reset values:** `an=4'b1111`, `seg=7'b1111111`, `busy=0`, `ovf=0`, `bcd=0`, digit index 0, blink phase 0, `pending=0`, FSM in IDLE, prev registers 0.
- Reset mid-conversion aborts the conversion; `bcd` keeps its reset value of 0.
- **Conversion latency:** `value_load` high at edge N → `busy=1` from N+1 → `bcd` updated and `busy=0` at edge N+16. The path is 1 capture cycle + 14 SHIFT cycles + 1 DONE cycle.
- **Scan latency:** the input is first sampled high at edge N → index updates at N → `an`/`seg` (registered) show the new digit from N+1.
- A new `bcd` value appears on the display from the next scan step onward; there is no forced rescan.
- Simultaneous 500 Hz and 2 Hz ticks are both honoured in the same cycle.
- `an` and `seg` are glitch-free, with all outputs registered.

## Test plan
- **Reset:** hold `reset=0` for 5 cycles → `an=1111`, `seg=1111111`, `busy=0`, `ovf=0`. Release → outputs stay off until the first 500 Hz tick.
- **Conversion:** pulse `value_load` with `value=1234` → `busy` high for exactly 15 cycles, `bcd=16'h1234` at edge +16. The 4 scan ticks then show `an` 1110/1101/1011/0111 with `seg` for 4, 3, 2, 1 (7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001).
- **Blanking:** load `value=7` → digit 0 shows 7'b1111000; at digit indices 1–3, `an=1111`. Load `value=0` → digit 0 shows 7'b1000000.
- **Overflow:** load `value=12000` → `ovf=1`, `bcd=16'h9999`. Then load `value=50` → `ovf=0`, `bcd=16'h0050`, digits 2–3 blanked.
- **Back-to-back:** load 100, then load 200 five cycles later → `busy` stays high continuously and the final `bcd=16'h0200` after 32 cycles.
- **Blink and reset:** with `blink_en=1`, the 1st 2 Hz tick forces `an=1111` and the 2nd restores the scan. Assert reset at SHIFT iteration 7 → `busy=0`, `bcd=0` the next cycle.
